// File: rtl/vseq_pkg.sv
// Shared types and defaults for the vector sequencer.
package vseq_pkg;

    localparam int unsigned DEF_WIDTH  = 4;
    localparam int unsigned DEF_SETTLE = 1;
    localparam int unsigned SCNT_W     = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_WAIT,
        ST_CHECK,
        ST_DONE
    } state_t;

endpackage

// File: rtl/vseq_parity_ref.sv
// Reference parity: XOR reduction of the driven vector.
module vseq_parity_ref #(
    parameter int unsigned WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    output logic             expected
);

    // Parity is order independent, so bit-reversed drive needs no change here.
    assign expected = ^a;

endmodule

// File: rtl/vector_sequencer.sv
// Exhaustive vector sequencer for a parity stage: drive, settle, check, count.
// Build option: VSEQ_BITREV_EN drives the bit-reversed index on a.
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned SETTLE = DEF_SETTLE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [WIDTH-1:0] a,
    input  logic             y,
    output logic             busy,
    output logic             done,
    output logic             err_pulse,
    output logic [WIDTH:0]   vectornum,
    output logic [WIDTH:0]   errors
);

    localparam int unsigned CNT_W = WIDTH + 1;
    localparam logic [WIDTH-1:0] IDX_LAST = '1;
    localparam logic [CNT_W-1:0] ERR_MAX  = '1;

    state_t              state;
    logic [WIDTH-1:0]    idx;
    logic [SCNT_W-1:0]   settle_cnt;
    logic [WIDTH-1:0]    drive_vec_c;
    logic                expected_c;

`ifdef VSEQ_BITREV_EN
    // Map index to the stage's reversed input ordering.
    always_comb begin
        drive_vec_c = '0;
        for (int k = 0; k < int'(WIDTH); k++) begin
            drive_vec_c[WIDTH-1-k] = idx[k];
        end
    end
`else
    // Drive the index directly.
    always_comb begin
        drive_vec_c = idx;
    end
`endif

    vseq_parity_ref #(
        .WIDTH(WIDTH)
    ) u_parity (
        .a        (a),
        .expected (expected_c)
    );

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            a          <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_pulse  <= 1'b0;
            vectornum  <= '0;
            errors     <= '0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state     <= ST_DRIVE;
                        idx       <= '0;
                        vectornum <= '0;
                        errors    <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                    end
                end
                ST_DRIVE: begin
                    a          <= drive_vec_c;
                    settle_cnt <= SCNT_W'(SETTLE);
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    settle_cnt <= settle_cnt - SCNT_W'(1);
                    if (settle_cnt == SCNT_W'(1)) begin
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    if (y != expected_c) begin
                        err_pulse <= 1'b1;
                        if (errors != ERR_MAX) begin
                            errors <= errors + CNT_W'(1);
                        end
                    end
                    vectornum <= vectornum + CNT_W'(1);
                    if (idx == IDX_LAST) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        idx   <= idx + WIDTH'(1);
                        state <= ST_DRIVE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vector_sequencer.sv
// Bench for vector_sequencer: two instances (SETTLE=1 and SETTLE=3) each
// driving a modelled parity stage whose behaviour is selected per sweep.
module tb_vector_sequencer;

    localparam int unsigned W = 4;
    localparam int NVEC = 16;

    logic clk;
    logic rst_n;
    logic [1:0]         start_s;
    logic [1:0][W-1:0]  a_s;
    logic [1:0]         y_s;
    logic [1:0]         busy_s;
    logic [1:0]         done_s;
    logic [1:0]         ep_s;
    logic [1:0][W:0]    vn_s;
    logic [1:0][W:0]    errs_s;
    logic [1:0][15:0]   flip_s;
    int                 mode_s [2];

    int n_checks;
    int n_errors;

    typedef struct {
        int dut;
        int mode;
        int exp_err;
        int exp_cyc;
    } vec_t;

    vector_sequencer #(.WIDTH(W), .SETTLE(1)) dut0 (
        .clk(clk), .reset(rst_n), .start(start_s[0]), .a(a_s[0]), .y(y_s[0]),
        .busy(busy_s[0]), .done(done_s[0]), .err_pulse(ep_s[0]),
        .vectornum(vn_s[0]), .errors(errs_s[0])
    );

    vector_sequencer #(.WIDTH(W), .SETTLE(3)) dut1 (
        .clk(clk), .reset(rst_n), .start(start_s[1]), .a(a_s[1]), .y(y_s[1]),
        .busy(busy_s[1]), .done(done_s[1]), .err_pulse(ep_s[1]),
        .vectornum(vn_s[1]), .errors(errs_s[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stage model: 0 correct, 1 stuck at 0, 2 inverted, 3 random faults per vector.
    function automatic logic stage(input logic [3:0] v, input int mode, input logic [15:0] flip);
        logic p;
        p = v[0] ^ v[1] ^ v[2] ^ v[3];
        case (mode)
            0: return p;
            1: return 1'b0;
            2: return ~p;
            default: return p ^ flip[v];
        endcase
    endfunction

    // Expected vector driven for sweep position v.
    function automatic logic [3:0] vmap(input int v);
        logic [3:0] t;
        logic [3:0] r;
        t = 4'(v);
`ifdef VSEQ_BITREV_EN
        for (int k = 0; k < 4; k++) r[3-k] = t[k];
`else
        r = t;
`endif
        return r;
    endfunction

    always_comb begin
        y_s[0] = stage(a_s[0], mode_s[0], flip_s[0]);
        y_s[1] = stage(a_s[1], mode_s[1], flip_s[1]);
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_zero(input int d, input string tag);
        chk({tag, "_a"}, int'(a_s[d]), 0);
        chk({tag, "_busy"}, int'(busy_s[d]), 0);
        chk({tag, "_done"}, int'(done_s[d]), 0);
        chk({tag, "_err_pulse"}, int'(ep_s[d]), 0);
        chk({tag, "_vectornum"}, int'(vn_s[d]), 0);
        chk({tag, "_errors"}, int'(errs_s[d]), 0);
    endtask

    // One full sweep on instance d; hold keeps start high throughout.
    task automatic run_sweep(input int d, input int mode, input int exp_err,
                             input int exp_cyc, input bit hold);
        int cycles;
        int busy_bad;
        int seq[$];
        int errv[$];
        int model_errv[$];
        logic [W:0] prev;
        logic [3:0] v;
        mode_s[d] = mode;
        if (mode == 3) flip_s[d] = 16'($urandom);
        for (int i = 0; i < NVEC; i++) begin
            v = vmap(i);
            if (stage(v, mode, flip_s[d]) != ^v) model_errv.push_back(int'(v));
        end
        if (exp_err < 0) exp_err = model_errv.size();
        @(negedge clk);
        start_s[d] = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_s[d] = 1'b0;
        prev = '0;
        cycles = 0;
        busy_bad = 0;
        while (cycles < 2000) begin
            @(posedge clk);
            cycles++;
            @(negedge clk);
            if (vn_s[d] != prev) begin
                seq.push_back(int'(a_s[d]));
                prev = vn_s[d];
            end
            if (ep_s[d]) errv.push_back(int'(a_s[d]));
            if (done_s[d]) break;
            if (!busy_s[d]) busy_bad++;
        end
        chk("done_reached", int'(done_s[d]), 1);
        chk("sweep_cycles", cycles, exp_cyc);
        chk("busy_in_sweep_low_cycles", busy_bad, 0);
        chk("busy_at_done", int'(busy_s[d]), 0);
        chk("vectornum_at_done", int'(vn_s[d]), NVEC);
        chk("errors_at_done", int'(errs_s[d]), exp_err);
        chk("seq_len", seq.size(), NVEC);
        for (int i = 0; i < seq.size() && i < NVEC; i++)
            chk($sformatf("seq_a[%0d]", i), seq[i], int'(vmap(i)));
        chk("err_pulse_count", errv.size(), model_errv.size());
        for (int i = 0; i < errv.size() && i < model_errv.size(); i++)
            chk($sformatf("err_vec[%0d]", i), errv[i], model_errv[i]);
    endtask

    vec_t tbl[7];

    initial begin
        n_checks = 0;
        n_errors = 0;
        start_s = '0;
        flip_s = '0;
        mode_s[0] = 0;
        mode_s[1] = 0;
        tbl[0] = '{0, 0, 0, 48};
        tbl[1] = '{0, 1, 8, 48};
        tbl[2] = '{0, 2, 16, 48};
        tbl[3] = '{1, 0, 0, 80};
        tbl[4] = '{1, 2, 16, 80};
        tbl[5] = '{0, 3, -1, 48};
        tbl[6] = '{1, 3, -1, 80};

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(0, "reset0");
        chk_zero(1, "reset1");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_no_start_busy", int'(busy_s[0]), 0);

        // Odd-parity vectors flagged with y stuck low.
        run_sweep(0, 1, 8, 48, 1'b0);
        begin
            int odd[8] = '{1, 2, 4, 7, 8, 11, 13, 14};
            int cnt = 0;
            for (int i = 0; i < NVEC; i++)
                if (stage(vmap(i), 1, 16'h0) != ^vmap(i)) begin
                    if (cnt < 8) chk($sformatf("odd_list[%0d]", cnt), int'(vmap(i)), odd[cnt]);
                    cnt++;
                end
        end

        for (int t = 0; t < 7; t++)
            run_sweep(tbl[t].dut, tbl[t].mode, tbl[t].exp_err, tbl[t].exp_cyc, 1'b0);

        // start held high: no restart while busy, restart on first DONE cycle.
        run_sweep(0, 1, 8, 48, 1'b1);
        @(posedge clk);
        @(negedge clk);
        chk("hold_restart_done", int'(done_s[0]), 0);
        chk("hold_restart_busy", int'(busy_s[0]), 1);
        chk("hold_restart_vectornum", int'(vn_s[0]), 0);
        chk("hold_restart_errors", int'(errs_s[0]), 0);
        start_s[0] = 1'b0;
        for (int i = 0; i < 200 && !done_s[0]; i++) @(negedge clk);
        chk("hold_second_done", int'(done_s[0]), 1);
        chk("hold_second_errors", int'(errs_s[0]), 8);

        // Reset mid-sweep during vector 5, then a clean sweep from 0.
        mode_s[0] = 0;
        @(negedge clk);
        start_s[0] = 1'b1;
        @(negedge clk);
        start_s[0] = 1'b0;
        for (int i = 0; i < 500 && vn_s[0] != 5; i++) @(negedge clk);
        chk("reach_vector5", int'(vn_s[0]), 5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero(0, "midreset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("no_resume_busy", int'(busy_s[0]), 0);
        chk("no_resume_vectornum", int'(vn_s[0]), 0);
        run_sweep(0, 0, 0, 48, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
